// File: rtl/detector_kn59_pkg.sv
// detector_kn59 shared types: window FSM states and default K/N.
// Optional DETKN_DONE_EN adds a registered window-end flag.
package detkn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DETECT,
        MISS
    } state_t;

    localparam int K_DEF = 5;
    localparam int N_DEF = 9;

endpackage

// File: rtl/detector_kn59_if.sv
// Serial bit-stream bus between the data source and detector_kn59.
// DETKN_DONE_EN adds the done flag to the bundle.
interface detector_kn59_if;

    logic dataIn;
    logic det59;
`ifdef DETKN_DONE_EN
    logic done;
`endif

`ifdef DETKN_DONE_EN
    modport master (
        output dataIn,
        input  det59,
        input  done
    );

    modport slave (
        input  dataIn,
        output det59,
        output done
    );
`else
    modport master (
        output dataIn,
        input  det59
    );

    modport slave (
        input  dataIn,
        output det59
    );
`endif

endinterface

// File: rtl/detector_kn59_sat_counter.sv
// Up-counter that sticks at LIMIT; async active-low clear.
module sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/detector_kn59.sv
// K-of-N detector: flags once K ones are seen in the first N bits.
// Define DETKN_DONE_EN for the registered window-end flag.
module detector_kn59
    import detkn_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int N = N_DEF
) (
    input  logic            clk,
    input  logic            reset,
    detector_kn59_if.slave  bus
);

    localparam int W = $clog2(N + 1);
    localparam logic [W-1:0] KL = W'(K);
    localparam logic [W-1:0] NL = W'(N);

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   bitCnt;
    logic [W-1:0]   oneCnt;
    logic [W-1:0]   bit_nx;
    logic [W-1:0]   one_nx;
    logic           counting;
    logic           det_q;

    // IDLE counts too: the first edge after release samples bit 1.
    always_comb begin
        counting = (state == IDLE) || (state == COUNT);
        bit_nx   = bitCnt + 1'b1;
        one_nx   = oneCnt + W'(bus.dataIn);
        state_nx = state;
        unique case (state)
            IDLE, COUNT: begin
                if (one_nx == KL) begin
                    state_nx = DETECT;
                end else if (bit_nx == NL) begin
                    state_nx = MISS;
                end else begin
                    state_nx = COUNT;
                end
            end
            DETECT: state_nx = DETECT;
            MISS:   state_nx = MISS;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            det_q <= 1'b0;
        end else begin
            state <= state_nx;
            det_q <= (state_nx == DETECT);
        end
    end

    sat_counter #(
        .W     (W),
        .LIMIT (N)
    ) u_bitcnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (counting),
        .cnt   (bitCnt)
    );

    sat_counter #(
        .W     (W),
        .LIMIT (K)
    ) u_onecnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (counting & bus.dataIn),
        .cnt   (oneCnt)
    );

    assign bus.det59 = det_q;

`ifdef DETKN_DONE_EN
    logic done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_nx == DETECT) || (state_nx == MISS);
        end
    end

    assign bus.done = done_q;
`endif

endmodule

// File: tb/tb_detector_kn59.sv
// Randomized + directed bench for detector_kn59 against a window model.
// Build with DETKN_DONE_EN to also check done.
module tb_detector_kn59;
    import detkn_pkg::*;

    localparam int K = K_DEF;
    localparam int N = N_DEF;
    localparam int WINDOWS = 4000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Model: ones among the first min(edges, N) bits of the window.
    int   m_bits = 0;
    int   m_ones = 0;

    detector_kn59_if bus ();

    detector_kn59 #(
        .K (K),
        .N (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic exp_det();
        return (m_ones >= K);
    endfunction

    function automatic logic exp_done();
        return (m_ones >= K) || (m_bits >= N);
    endfunction

    task automatic check_outs(input string tag);
        check({tag, ".det"}, {31'd0, bus.det59}, {31'd0, exp_det()});
`ifdef DETKN_DONE_EN
        check({tag, ".done"}, {31'd0, bus.done}, {31'd0, exp_done()});
`endif
    endtask

    // Called just after a rising edge; pulses reset without a clock edge.
    task automatic new_window(input string tag);
        reset = 1'b0;
        #1;
        m_bits = 0;
        m_ones = 0;
        check_outs({tag, ".rst"});
        #1;
        reset = 1'b1;
    endtask

    task automatic step(input logic b, input string tag);
        bus.dataIn = b;
        @(posedge clk);
        #1;
        if (m_bits < N) begin
            m_bits++;
            if (b) m_ones++;
        end
        check_outs(tag);
    endtask

    task automatic run_pat(input logic [31:0] pat, input int len,
                           input string tag);
        for (int i = 0; i < len; i++) begin
            step(pat[len-1-i], tag);
        end
    endtask

    int hits_dut;
    int hits_ref;

    initial begin
        bus.dataIn = 1'b0;
        reset = 1'b0;
        #12;
        check_outs("reset");
        @(posedge clk);
        #1;
        check_outs("reset_hold");
        #1;
        reset = 1'b1;

        // all ones: rises after edge 5, sticky through edge 20
        run_pat(32'hFFFFF, 20, "ones");
        new_window("w1");
        // all zeros: never detects, done after edge 9
        run_pat(32'h0, 20, "zeros");
        new_window("w2");
        // K-th one on the last window bit
        run_pat(32'b000011111, 9, "last");
        run_pat(32'hFF, 8, "last_tail");
        new_window("w3");
        // miss then ones: stays 0 until reset
        run_pat(32'b1111000001111111111, 19, "miss");
        new_window("w4");
        // reset mid-window
        run_pat(32'b111, 3, "mid_a");
        new_window("mid");
        run_pat(32'b11111, 5, "mid_b");
        check("mid_b.final", {31'd0, bus.det59}, 32'd1);

        hits_dut = 0;
        hits_ref = 0;
        for (int w = 0; w < WINDOWS; w++) begin
            new_window("rnd_w");
            for (int e = 0; e < N; e++) begin
                step(1'($urandom_range(1, 0)), "rnd");
            end
            if (bus.det59) hits_dut++;
            if (exp_det()) hits_ref++;
        end
        check("rnd.hits", hits_dut, hits_ref);
        check("rnd.rate_lo", {31'd0, hits_dut >= WINDOWS * 47 / 100}, 32'd1);
        check("rnd.rate_hi", {31'd0, hits_dut <= WINDOWS * 53 / 100}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
